memory_accessor: RTL and testbench

- Memory-access pipeline stage directly downstream of the executor. Upstream handshake is executor_valid/accessor_ready; downstream handshake is accessor_valid/writeback_ready to the writeback stage.
- Forwards ALU results unchanged and implements LUI.
- Runs loads and stores on a single-outstanding valid/ready data bus: byte-lane strobes, load sign/zero extension, misalignment trapping.
- One instruction in flight at a time.

---
 rtl/memory_accessor_if.sv | 28 ++
 rtl/memory_accessor.sv | 242 ++++++++++++++++++++++++
 tb/tb_memory_accessor.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_accessor_if.sv
// Single-outstanding valid/ready data bus between the memory-access stage and memory.
// The accessor drives requests (master); the memory side answers with ready/rdata (slave).
interface memory_accessor_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/memory_accessor.sv
// Memory-access pipeline stage: forwards ALU/LUI results, runs loads and stores on a
// single-outstanding data bus, and traps misaligned accesses and bus timeouts.
//
// state | meaning
// IDLE  | empty, accessor_ready high
// MEM   | bus request outstanding
// HOLD  | result valid, waiting for writeback
module memory_accessor #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     executor_valid,
    output logic                     accessor_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_rd_data,
    input  logic [31:0]              in_mem_addr,
    input  logic [31:0]              in_mem_data,
    input  logic                     in_is_lui,
    input  logic                     in_is_lb,
    input  logic                     in_is_lbu,
    input  logic                     in_is_lh,
    input  logic                     in_is_lhu,
    input  logic                     in_is_lw,
    input  logic                     in_is_sb,
    input  logic                     in_is_sh,
    input  logic                     in_is_sw,
    memory_accessor_if.master        mem,
    output logic                     accessor_valid,
    input  logic                     writeback_ready,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_rd_data,
    output logic                     out_write,
    output logic                     out_trap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    // size codes for the pending load
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        write_q, write_d;
    logic        trap_q, trap_d;
    logic [1:0]  lane_q, lane_d;
    logic        is_load_q, is_load_d;
    logic        ld_signed_q, ld_signed_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic [31:0] cnt_q, cnt_d;

    logic        is_load_in;
    logic        is_store_in;
    logic        misaligned_in;
    logic        timeout_hit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

    assign is_load_in    = in_is_lb | in_is_lbu | in_is_lh | in_is_lhu | in_is_lw;
    assign is_store_in   = in_is_sb | in_is_sh | in_is_sw;
    assign misaligned_in = ((in_is_lh | in_is_lhu | in_is_sh) & in_mem_addr[0]) |
                           ((in_is_lw | in_is_sw) & (in_mem_addr[1:0] != 2'b00));
    // counter holds the number of stalled MEM cycles already spent
    assign timeout_hit   = (TO_LIMIT != 32'd0) && ((cnt_q + 32'd1) == TO_LIMIT);

    // select the addressed lane of the returned read data and extend it
    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = 16'h0000;
        ld_result = 32'h0000_0000;
        case (lane_q)
            2'd0:    ld_byte = mem.mem_rdata[7:0];
            2'd1:    ld_byte = mem.mem_rdata[15:8];
            2'd2:    ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (ld_size_q)
            SZ_BYTE: ld_result = ld_signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            SZ_HALF: ld_result = ld_signed_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            default: ld_result = mem.mem_rdata;
        endcase
    end

    // next-state and next-register logic for the accept/bus/hold sequence
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rd_d        = rd_q;
        rd_data_d   = rd_data_q;
        write_d     = write_q;
        trap_d      = trap_q;
        lane_d      = lane_q;
        is_load_d   = is_load_q;
        ld_signed_d = ld_signed_q;
        ld_size_d   = ld_size_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (executor_valid) begin
                    rd_d   = in_rd;
                    lane_d = in_mem_addr[1:0];
                    cnt_d  = 32'd0;
                    if (misaligned_in) begin
                        state_d   = HOLD;
                        trap_d    = 1'b1;
                        write_d   = 1'b0;
                        rd_data_d = in_mem_addr;
                    end else if (is_load_in || is_store_in) begin
                        state_d     = MEM;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {in_mem_addr[31:2], 2'b00};
                        trap_d      = 1'b0;
                        is_load_d   = is_load_in;
                        ld_signed_d = in_is_lb | in_is_lh;
                        ld_size_d   = (in_is_lb | in_is_lbu) ? SZ_BYTE :
                                      (in_is_lh | in_is_lhu) ? SZ_HALF : SZ_WORD;
                        mem_wstrb_d = 4'b0000;
                        mem_wdata_d = 32'h0000_0000;
                        if (in_is_sb) begin
                            mem_wstrb_d = 4'b0001 << in_mem_addr[1:0];
                            mem_wdata_d = {4{in_mem_data[7:0]}};
                        end else if (in_is_sh) begin
                            mem_wstrb_d = 4'b0011 << {in_mem_addr[1], 1'b0};
                            mem_wdata_d = {2{in_mem_data[15:0]}};
                        end else if (in_is_sw) begin
                            mem_wstrb_d = 4'b1111;
                            mem_wdata_d = in_mem_data;
                        end
                    end else begin
                        state_d   = HOLD;
                        trap_d    = 1'b0;
                        write_d   = (in_rd != 5'd0);
                        rd_data_d = in_is_lui ? in_mem_addr : in_rd_data;
                    end
                end
            end
            MEM: begin
                if (mem.mem_ready) begin
                    state_d     = HOLD;
                    mem_valid_d = 1'b0;
                    trap_d      = 1'b0;
                    if (is_load_q) begin
                        rd_data_d = ld_result;
                        write_d   = (rd_q != 5'd0);
                    end else begin
                        rd_data_d = 32'h0000_0000;
                        write_d   = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d     = HOLD;
                    mem_valid_d = 1'b0;
                    trap_d      = 1'b1;
                    write_d     = 1'b0;
                    rd_data_d   = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HOLD: begin
                if (writeback_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
            rd_q        <= 5'd0;
            rd_data_q   <= 32'h0;
            write_q     <= 1'b0;
            trap_q      <= 1'b0;
            lane_q      <= 2'd0;
            is_load_q   <= 1'b0;
            ld_signed_q <= 1'b0;
            ld_size_q   <= SZ_BYTE;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rd_q        <= rd_d;
            rd_data_q   <= rd_data_d;
            write_q     <= write_d;
            trap_q      <= trap_d;
            lane_q      <= lane_d;
            is_load_q   <= is_load_d;
            ld_signed_q <= ld_signed_d;
            ld_size_q   <= ld_size_d;
            cnt_q       <= cnt_d;
        end
    end

    assign accessor_ready = (state_q == IDLE);
    assign accessor_valid = (state_q == HOLD);
    assign out_rd         = rd_q;
    assign out_rd_data    = rd_data_q;
    assign out_write      = write_q;
    assign out_trap       = trap_q;
    assign mem.mem_valid  = mem_valid_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_wstrb  = mem_wstrb_q;

    a_mem_valid_in_mem: assert property (@(posedge clk) disable iff (reset)
        mem_valid_q |-> (state_q == MEM));

    a_bus_stable: assert property (@(posedge clk) disable iff (reset)
        (mem_valid_q && !mem.mem_ready) |=>
        ($stable(mem_addr_q) && $stable(mem_wdata_q) && $stable(mem_wstrb_q)));

endmodule

// File: tb/tb_memory_accessor.sv
// Randomized self-checking bench for memory_accessor against a behavioural model.
module tb_memory_accessor;
    localparam int TO = 4;
    localparam int OP_ALU = 0, OP_LUI = 1, OP_LB = 2, OP_LBU = 3, OP_LH = 4,
                   OP_LHU = 5, OP_LW = 6, OP_SB = 7, OP_SH = 8, OP_SW = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        executor_valid = 1'b0;
    logic        accessor_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_rd_data = '0, in_mem_addr = '0, in_mem_data = '0;
    logic        in_is_lui = 0, in_is_lb = 0, in_is_lbu = 0, in_is_lh = 0, in_is_lhu = 0;
    logic        in_is_lw = 0, in_is_sb = 0, in_is_sh = 0, in_is_sw = 0;
    logic        accessor_valid;
    logic        writeback_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_rd_data;
    logic        out_write, out_trap;

    memory_accessor_if bus();

    memory_accessor #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .executor_valid(executor_valid), .accessor_ready(accessor_ready),
        .in_rd(in_rd), .in_rd_data(in_rd_data), .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data),
        .in_is_lui(in_is_lui), .in_is_lb(in_is_lb), .in_is_lbu(in_is_lbu), .in_is_lh(in_is_lh),
        .in_is_lhu(in_is_lhu), .in_is_lw(in_is_lw), .in_is_sb(in_is_sb), .in_is_sh(in_is_sh),
        .in_is_sw(in_is_sw),
        .mem(bus.master),
        .accessor_valid(accessor_valid), .writeback_ready(writeback_ready),
        .out_rd(out_rd), .out_rd_data(out_rd_data), .out_write(out_write), .out_trap(out_trap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observations of the last transaction
    int          obs_lat, obs_memc;
    logic        obs_mem_seen, obs_mem_unstable, obs_stuck, obs_hold_bad, obs_release_ok;
    logic [31:0] obs_addr, obs_wdata, obs_rd_data;
    logic [3:0]  obs_wstrb;
    logic [4:0]  obs_rd;
    logic        obs_write, obs_trap;

    function automatic logic is_mem_op(input int op);
        return op >= OP_LB;
    endfunction

    function automatic logic is_misaligned(input int op, input logic [31:0] addr);
        if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (addr % 2 != 0)) return 1'b1;
        if ((op == OP_LW || op == OP_SW) && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int lane;
        lane = int'(addr % 4);
        v = rdata;
        if (op == OP_LB || op == OP_LBU) begin
            v = (rdata >> (8 * lane)) & 32'hFF;
            if (op == OP_LB && v >= 32'd128) v = v - 32'd256;
        end else if (op == OP_LH || op == OP_LHU) begin
            v = (rdata >> (8 * (lane / 2) * 2)) & 32'hFFFF;
            if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input int op, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        if (op == OP_SB) return 4'(1 << lane);
        if (op == OP_SH) return 4'(3 << ((lane / 2) * 2));
        if (op == OP_SW) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_wdata(input int op, input logic [31:0] d);
        if (op == OP_SB) return (d & 32'hFF) * 32'h0101_0101;
        if (op == OP_SH) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic set_flags(input int op);
        in_is_lui = (op == OP_LUI); in_is_lb = (op == OP_LB); in_is_lbu = (op == OP_LBU);
        in_is_lh = (op == OP_LH); in_is_lhu = (op == OP_LHU); in_is_lw = (op == OP_LW);
        in_is_sb = (op == OP_SB); in_is_sh = (op == OP_SH); in_is_sw = (op == OP_SW);
    endtask

    // drives one instruction through accept, bus phase and writeback; records observations only
    task automatic do_op(input int op, input logic [4:0] rd, input logic [31:0] rd_data,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                         input int stall, input int wb_stall);
        int memc;
        set_flags(op);
        in_rd = rd; in_rd_data = rd_data; in_mem_addr = addr; in_mem_data = sdata;
        executor_valid = 1'b1; writeback_ready = 1'b0;
        bus.mem_ready = (stall == 0); bus.mem_rdata = rdata;
        @(posedge clk); #1;
        executor_valid = 1'b0; set_flags(OP_ALU);
        in_rd = '0; in_rd_data = '0; in_mem_addr = '0; in_mem_data = '0;
        obs_lat = 1; memc = 0; obs_mem_seen = 0; obs_mem_unstable = 0; obs_stuck = 0;
        obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
        while (!accessor_valid) begin
            if (bus.mem_valid) begin
                memc++;
                if (!obs_mem_seen) begin
                    obs_mem_seen = 1; obs_addr = bus.mem_addr;
                    obs_wdata = bus.mem_wdata; obs_wstrb = bus.mem_wstrb;
                end else if (obs_addr !== bus.mem_addr || obs_wdata !== bus.mem_wdata ||
                             obs_wstrb !== bus.mem_wstrb) begin
                    obs_mem_unstable = 1;
                end
                bus.mem_ready = (memc > stall);
            end
            if (obs_lat >= 60) begin obs_stuck = 1; break; end
            @(posedge clk); #1;
            obs_lat++;
        end
        bus.mem_ready = 1'b0;
        obs_memc = memc;
        obs_rd = out_rd; obs_rd_data = out_rd_data; obs_write = out_write; obs_trap = out_trap;
        obs_hold_bad = 0;
        for (int i = 0; i < wb_stall; i++) begin
            @(posedge clk); #1;
            if (!accessor_valid || accessor_ready || bus.mem_valid || out_rd !== obs_rd ||
                out_rd_data !== obs_rd_data || out_write !== obs_write || out_trap !== obs_trap)
                obs_hold_bad = 1;
        end
        writeback_ready = 1'b1;
        @(posedge clk); #1;
        obs_release_ok = !accessor_valid && accessor_ready;
        writeback_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_valid); end
        checks++; if (accessor_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid: got %b want 0", accessor_valid); end
        checks++; if (accessor_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready: got %b want 1", accessor_ready); end
        checks++; if ({out_rd, out_rd_data, out_write, out_trap, bus.mem_wstrb} !== '0) begin
            errors++; $display("FAIL reset_outputs: got rd=%0d data=%h w=%b t=%b strb=%h want all 0",
                               out_rd, out_rd_data, out_write, out_trap, bus.mem_wstrb); end
    endtask

    task automatic test_alu();
        do_op(OP_ALU, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 0, 0);
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL alu_latency: got %0d want 1", obs_lat); end
        checks++; if (obs_mem_seen !== 1'b0) begin errors++; $display("FAIL alu_no_bus: got %b want 0", obs_mem_seen); end
        checks++; if ({obs_rd, obs_rd_data, obs_write, obs_trap} !== {5'd5, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL alu_result: got rd=%0d data=%h w=%b t=%b want rd=5 data=deadbeef w=1 t=0",
                               obs_rd, obs_rd_data, obs_write, obs_trap); end
        checks++; if (obs_release_ok !== 1'b1) begin errors++; $display("FAIL alu_release: got %b want 1", obs_release_ok); end
    endtask

    task automatic test_load_ext();
        do_op(OP_LB, 5'd7, 32'h0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
        checks++; if (obs_addr !== 32'h1000 || obs_wstrb !== 4'h0) begin
            errors++; $display("FAIL lb_bus: got addr=%h strb=%h want addr=1000 strb=0", obs_addr, obs_wstrb); end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d want 2", obs_lat); end
        checks++; if (obs_rd_data !== 32'hFFFFFF80 || obs_write !== 1'b1) begin
            errors++; $display("FAIL lb_data: got %h w=%b want ffffff80 w=1", obs_rd_data, obs_write); end
        do_op(OP_LBU, 5'd7, 32'h0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
        checks++; if (obs_rd_data !== 32'h00000080) begin
            errors++; $display("FAIL lbu_data: got %h want 00000080", obs_rd_data); end
    endtask

    task automatic test_store_stall();
        do_op(OP_SH, 5'd9, 32'h0, 32'h2002, 32'h1234ABCD, 32'h0, 3, 0);
        checks++; if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h2000) begin
            errors++; $display("FAIL sh_bus: got strb=%b wdata=%h addr=%h want 1100 abcdabcd 2000",
                               obs_wstrb, obs_wdata, obs_addr); end
        checks++; if (obs_mem_unstable !== 1'b0 || obs_memc !== 4) begin
            errors++; $display("FAIL sh_stall: got unstable=%b mem_cycles=%0d want 0 4", obs_mem_unstable, obs_memc); end
        checks++; if (obs_write !== 1'b0 || obs_rd_data !== 32'h0 || obs_trap !== 1'b0) begin
            errors++; $display("FAIL sh_result: got w=%b data=%h t=%b want 0 0 0", obs_write, obs_rd_data, obs_trap); end
    endtask

    task automatic test_misaligned();
        do_op(OP_LW, 5'd3, 32'h0, 32'h3001, 32'h0, 32'h0, 0, 0);
        checks++; if (obs_mem_seen !== 1'b0 || obs_lat !== 1) begin
            errors++; $display("FAIL lw_misaligned_bus: got seen=%b lat=%0d want 0 1", obs_mem_seen, obs_lat); end
        checks++; if (obs_trap !== 1'b1 || obs_write !== 1'b0 || obs_rd_data !== 32'h3001) begin
            errors++; $display("FAIL lw_misaligned_result: got t=%b w=%b data=%h want 1 0 00003001",
                               obs_trap, obs_write, obs_rd_data); end
    endtask

    task automatic test_timeout();
        do_op(OP_LW, 5'd3, 32'h0, 32'h3000, 32'h0, 32'h0, 1000, 0);
        checks++; if (obs_stuck !== 1'b0 || obs_memc !== TO || obs_lat !== TO + 1) begin
            errors++; $display("FAIL timeout_cycles: got stuck=%b mem_cycles=%0d lat=%0d want 0 %0d %0d",
                               obs_stuck, obs_memc, obs_lat, TO, TO + 1); end
        checks++; if (obs_trap !== 1'b1 || obs_write !== 1'b0) begin
            errors++; $display("FAIL timeout_result: got t=%b w=%b want 1 0", obs_trap, obs_write); end
    endtask

    task automatic test_lui_hold();
        do_op(OP_LUI, 5'd12, 32'h5555_5555, 32'hABCDE000, 32'h0, 32'h0, 0, 2);
        checks++; if (obs_rd_data !== 32'hABCDE000 || obs_rd !== 5'd12 || obs_write !== 1'b1) begin
            errors++; $display("FAIL lui_result: got data=%h rd=%0d w=%b want abcde000 12 1",
                               obs_rd_data, obs_rd, obs_write); end
        checks++; if (obs_hold_bad !== 1'b0) begin errors++; $display("FAIL lui_hold_stable: got %b want 0", obs_hold_bad); end
        checks++; if (obs_release_ok !== 1'b1) begin errors++; $display("FAIL lui_release: got %b want 1", obs_release_ok); end
    endtask

    task automatic test_reset_mid_mem();
        set_flags(OP_LW);
        in_rd = 5'd4; in_mem_addr = 32'h4000; executor_valid = 1'b1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        executor_valid = 1'b0; set_flags(OP_ALU); in_mem_addr = '0;
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rst_mem_entered: got %b want 1", bus.mem_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.mem_valid !== 1'b0 || accessor_valid !== 1'b0 || accessor_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_mem: got mv=%b av=%b ar=%b want 0 0 1",
                               bus.mem_valid, accessor_valid, accessor_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int op, stall, wbs, exp_lat;
        logic [4:0] rd;
        logic [31:0] rdd, addr, sd, rdata;
        logic mis, tmo;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9); rd = 5'($urandom_range(0, 31));
            rdd = $urandom; addr = $urandom; sd = $urandom; rdata = $urandom;
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
            stall = $urandom_range(0, 5); wbs = $urandom_range(0, 2);
            do_op(op, rd, rdd, addr, sd, rdata, stall, wbs);
            mis = is_mem_op(op) && is_misaligned(op, addr);
            tmo = is_mem_op(op) && !mis && (stall >= TO);
            exp_lat = (!is_mem_op(op) || mis) ? 1 : (tmo ? TO + 1 : stall + 2);
            checks++; if (obs_lat !== exp_lat || obs_stuck !== 1'b0) begin
                errors++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", n, op, obs_lat, exp_lat); end
            checks++; if (obs_mem_seen !== (is_mem_op(op) && !mis)) begin
                errors++; $display("FAIL rand_bus_used[%0d] op=%0d: got %b", n, op, obs_mem_seen); end
            checks++; if (obs_trap !== (mis || tmo) || obs_rd !== rd) begin
                errors++; $display("FAIL rand_trap[%0d] op=%0d: got t=%b rd=%0d want t=%b rd=%0d",
                                   n, op, obs_trap, obs_rd, mis || tmo, rd); end
            if (is_mem_op(op) && !mis) begin
                checks++; if (obs_addr !== (addr & 32'hFFFF_FFFC) || obs_wstrb !== model_strb(op, addr) ||
                              obs_mem_unstable !== 1'b0) begin
                    errors++; $display("FAIL rand_bus[%0d] op=%0d: got addr=%h strb=%h unstable=%b want addr=%h strb=%h",
                                       n, op, obs_addr, obs_wstrb, obs_mem_unstable,
                                       addr & 32'hFFFF_FFFC, model_strb(op, addr)); end
                if (op >= OP_SB) begin
                    checks++; if (obs_wdata !== model_wdata(op, sd)) begin
                        errors++; $display("FAIL rand_wdata[%0d] op=%0d: got %h want %h", n, op, obs_wdata, model_wdata(op, sd)); end
                end
            end
            if (mis) begin
                checks++; if (obs_rd_data !== addr || obs_write !== 1'b0) begin
                    errors++; $display("FAIL rand_mis_result[%0d]: got data=%h w=%b want %h 0", n, obs_rd_data, obs_write, addr); end
            end else if (tmo) begin
                checks++; if (obs_write !== 1'b0) begin errors++; $display("FAIL rand_tmo_write[%0d]: got %b want 0", n, obs_write); end
            end else if (op >= OP_SB) begin
                checks++; if (obs_rd_data !== 32'h0 || obs_write !== 1'b0) begin
                    errors++; $display("FAIL rand_store_result[%0d]: got data=%h w=%b want 0 0", n, obs_rd_data, obs_write); end
            end else begin
                checks++; if (obs_rd_data !== (op == OP_ALU ? rdd : op == OP_LUI ? addr : model_load(op, addr, rdata)) ||
                              obs_write !== (rd != 5'd0)) begin
                    errors++; $display("FAIL rand_result[%0d] op=%0d: got data=%h w=%b want %h %b", n, op, obs_rd_data, obs_write,
                                       (op == OP_ALU ? rdd : op == OP_LUI ? addr : model_load(op, addr, rdata)), rd != 5'd0); end
            end
            checks++; if (obs_hold_bad !== 1'b0 || obs_release_ok !== 1'b1) begin
                errors++; $display("FAIL rand_handshake[%0d]: got hold_bad=%b release=%b want 0 1", n, obs_hold_bad, obs_release_ok); end
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_alu();
        test_load_ext();
        test_store_stall();
        test_misaligned();
        test_timeout();
        test_lui_hold();
        test_reset_mid_mem();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
